enc4_rr_arbiter: RTL and testbench

- Sequential 4-requester round-robin arbiter built around the 4-to-2 encoding function.
- Shares one downstream resource between four requesters and grants exactly one of them at a time.
- Grant is held until the winner releases its request or a hold timeout expires.
- Outputs a one-hot grant and the encoded 2-bit grant index, with a valid flag that disambiguates index 0 from "no grant".

---
 rtl/enc4_arb_pkg.sv | 27 ++
 rtl/enc4_rr_arbiter_if.sv | 22 ++
 rtl/enc4_onehot_to_id.sv | 13 +
 rtl/enc4_rr_arbiter.sv | 112 +++++++++++
 tb/tb_enc4_rr_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/enc4_arb_pkg.sv
// Shared types, sizes and the round-robin pick function for the
// 4-requester arbiter.
package enc4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Searches last+1, last+2, last+3, then last (mod 4). The loop runs from
  // the farthest offset down so the nearest requester is the one assigned
  // last and therefore wins. Returns last when nothing is requesting; the
  // caller only uses the result when req is non-zero.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    rr_pick = last;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = last + ID_W'(off);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/enc4_rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the
// arbiter (slave).
interface enc4_rr_arbiter_if;

  logic [enc4_arb_pkg::NUM_REQ-1:0] req;
  logic [enc4_arb_pkg::NUM_REQ-1:0] gnt;
  logic [enc4_arb_pkg::ID_W-1:0]    gnt_id;
  logic                             gnt_valid;
  logic                             timeout;
  logic                             busy;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, timeout, busy
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, timeout, busy
  );

endinterface

// File: rtl/enc4_onehot_to_id.sv
// Combinational 4-to-2 encoder for a one-hot (or all-zero) grant vector.
// An all-zero input encodes to 0; gnt_valid tells that apart from index 0.
module enc4_onehot_to_id
  import enc4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    id
);

  assign id[0] = onehot[1] | onehot[3];
  assign id[1] = onehot[2] | onehot[3];

endmodule

// File: rtl/enc4_rr_arbiter.sv
// Round-robin arbiter for four requesters with a hold timeout.
// All outputs are registered; MAX_HOLD must be 1..255 with 2**CNT_W > MAX_HOLD.
module enc4_rr_arbiter
  import enc4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  enc4_rr_arbiter_if.slave  bus
);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                timeout_q, timeout_d;
  logic [ID_W-1:0]     pick;

  assign pick = rr_pick(bus.req, last_q);

  // gnt_id is encoded from the next grant and registered alongside it, so
  // the two outputs always change on the same edge.
  enc4_onehot_to_id u_enc (
    .onehot (gnt_d),
    .id     (gnt_id_d)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        if (|bus.req) begin
          gnt_d[pick] = 1'b1;
          gnt_valid_d = 1'b1;
          last_d      = pick;
          hold_cnt_d  = CNT_W'(1);
          state_d     = GRANT;
        end
      end

      GRANT: begin
        // Other requesters never pre-empt; only release or timeout end a grant.
        if (!bus.req[gnt_id_q]) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          state_d     = IDLE;
        end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // last resets to 3 so requester 0 is searched first after reset.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_enc4_rr_arbiter.sv
// Directed and randomised checks for enc4_rr_arbiter with MAX_HOLD=8.
module tb_enc4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  enc4_rr_arbiter_if bus ();

  enc4_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_id(input logic [3:0] g);
    case (g)
      4'b0010: exp_id = 2'd1;
      4'b0100: exp_id = 2'd2;
      4'b1000: exp_id = 2'd3;
      default: exp_id = 2'd0;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   bus.gnt,       4'b0000);
    check({tag, "_id"},    bus.gnt_id,    2'd0);
    check({tag, "_valid"}, bus.gnt_valid, 1'b0);
    check({tag, "_to"},    bus.timeout,   1'b0);
    check({tag, "_busy"},  bus.busy,      1'b0);
  endtask

  initial begin
    int          rr_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  e;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  prev_gnt;
    int          run_len;
    int          wait_cnt [4];
    logic [1:0]  w;

    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0000;

    // Reset values
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;

    // No requests for 10 cycles
    for (int c = 0; c < 10; c++) begin
      tick();
      check_idle("no_req");
    end

    // All requesting, each winner releases after 2 cycles: order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << rr_order[k];
      bus.req = 4'b1111;
      tick();
      check("rr_gnt",   bus.gnt,       e);
      check("rr_id",    bus.gnt_id,    rr_order[k]);
      check("rr_valid", bus.gnt_valid, 1'b1);
      check("rr_busy",  bus.busy,      1'b1);
      tick();
      check("rr_hold",  bus.gnt,       e);
      bus.req = 4'b1111 & ~e;
      tick();
      check("rr_gap",   bus.gnt,       4'b0000);
      check("rr_gap_to", bus.timeout,  1'b0);
    end
    bus.req = 4'b0000;
    tick();

    // Requester 2 alone: 8 granted cycles, one timeout cycle, period 9
    bus.req = 4'b0100;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if ((c - 1) % 9 < 8) begin
        check("to_gnt",   bus.gnt,     4'b0100);
        check("to_id",    bus.gnt_id,  2'd2);
        check("to_pulse", bus.timeout, 1'b0);
      end else begin
        check("to_gap",   bus.gnt,       4'b0000);
        check("to_valid", bus.gnt_valid, 1'b0);
        check("to_pulse", bus.timeout,   1'b1);
      end
    end
    bus.req = 4'b0000;
    tick();
    check("to_clear", bus.timeout, 1'b0);

    // No pre-emption: requester 0 keeps the grant while 1 and 3 also request
    bus.req = 4'b0001;
    tick();
    check("np_gnt1", bus.gnt, 4'b0001);
    tick();
    check("np_gnt2", bus.gnt, 4'b0001);
    bus.req = 4'b1011;
    tick();
    check("np_gnt3", bus.gnt, 4'b0001);
    tick();
    check("np_gnt4", bus.gnt, 4'b0001);
    bus.req = 4'b1010;
    tick();
    check("np_release", bus.gnt, 4'b0000);
    tick();
    check("np_next",    bus.gnt,    4'b0010);
    check("np_next_id", bus.gnt_id, 2'd1);

    // Asynchronous reset mid-grant, then last restored to 3
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_win",    bus.gnt,    4'b0010);
    check("rst_win_id", bus.gnt_id, 2'd1);
    bus.req = 4'b0000;
    tick();
    tick();
    check_idle("pre_rand");

    // Randomised requests with sticky bits so grants last long enough to time out
    r        = 4'b0000;
    prev_gnt = 4'b0000;
    run_len  = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(3) == 0) r[$urandom_range(3)] = ~r[$urandom_range(3)];
      if ($urandom_range(7) == 0) r = 4'($urandom_range(15));
      bus.req = r;
      tick();
      g = bus.gnt;
      check("rnd_onehot", ($countones(g) <= 1), 1'b1);
      check("rnd_valid",  bus.gnt_valid, |g);
      check("rnd_id",     bus.gnt_id,    exp_id(g));
      check("rnd_busy",   bus.busy,      |g);
      if (g != 4'b0000) begin
        if (prev_gnt != 4'b0000) check("rnd_no_switch", g, prev_gnt);
        run_len = (prev_gnt == g) ? run_len + 1 : 1;
        check("rnd_hold_max", (run_len <= MAX_HOLD), 1'b1);
        if (prev_gnt == 4'b0000) begin
          w = exp_id(g);
          for (int i = 0; i < 4; i++) begin
            if (i == int'(w)) wait_cnt[i] = 0;
            else if (r[i])    wait_cnt[i]++;
          end
        end
      end else begin
        if (bus.timeout) check("rnd_to_len", run_len, MAX_HOLD);
        run_len = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) wait_cnt[i] = 0;
        else       check("rnd_fair", (wait_cnt[i] <= 3), 1'b1);
      end
      prev_gnt = g;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
